// File: rtl/dot_bank_scheduler.sv
// dot_bank_scheduler: ping-pong capture/display bank controller for the constellation dot RAM
module dot_bank_scheduler #(
    parameter int DEPTH = 64,
    parameter int X_W = 12,
    parameter int Y_W = 11,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_pixel,
    input  logic              rst,
    input  logic              sym_valid,
    input  logic [X_W-1:0]    sym_x,
    input  logic [Y_W-1:0]    sym_y,
    input  logic              frame_start,
    input  logic [3:0]        cfg_persist,
    input  logic [7:0]        cfg_decim,
    output logic              wr_en,
    output logic              wr_valid,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [X_W-1:0]    wr_x,
    output logic [Y_W-1:0]    wr_y,
    output logic              disp_bank,
    output logic [ADDR_W:0]   disp_count,
    output logic              disp_overflow,
    output logic [15:0]       drop_cnt,
    output logic              busy
);
    typedef enum logic [1:0] {INIT, CLEAR, CAPTURE} state_t;

    localparam logic [ADDR_W:0] SWEEP_INIT_LAST = '1;
    localparam logic [ADDR_W:0] SWEEP_CLEAR_END = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, state_next;
    logic [ADDR_W:0] sweep, wr_ptr;
    logic            cap_bank, ovf_pend, swap, full, open, eligible, drop;
    logic [3:0]      frame_cnt, persist_l;
    logic [7:0]      dec_cnt, decim_l, decim_eff;
    logic [4:0]      persist_eff;

    assign busy = state != CAPTURE;

    // Swap decision, symbol eligibility and next state; a swapping frame_start pre-empts any symbol
    always_comb begin
        persist_eff = (persist_l == 4'd0) ? 5'd1 : {1'b0, persist_l};
        decim_eff   = (decim_l == 8'd0) ? 8'd1 : decim_l;
        full        = wr_ptr[ADDR_W];
        swap        = (state == CAPTURE) && frame_start && ({1'b0, frame_cnt} + 5'd1 >= persist_eff);
        open        = (state == CAPTURE) && !swap;
        eligible    = open && sym_valid && !full;
        drop        = sym_valid && !eligible;
        state_next  = swap ? CLEAR
                    : ((state == INIT && sweep == SWEEP_INIT_LAST) ||
                       (state == CLEAR && sweep == SWEEP_CLEAR_END)) ? CAPTURE
                    : state;
    end

    // State register
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    // Bank sweeps, symbol capture, swap bookkeeping and the registered RAM write port
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            sweep         <= '0;
            wr_ptr        <= '0;
            cap_bank      <= 1'b0;
            ovf_pend      <= 1'b0;
            frame_cnt     <= '0;
            dec_cnt       <= '0;
            persist_l     <= 4'd1;
            decim_l       <= 8'd1;
            drop_cnt      <= '0;
            disp_bank     <= 1'b1;
            disp_count    <= '0;
            disp_overflow <= 1'b0;
            wr_en         <= 1'b0;
            wr_valid      <= 1'b0;
            wr_bank       <= 1'b0;
            wr_addr       <= '0;
            wr_x          <= '0;
            wr_y          <= '0;
        end else begin
            wr_en    <= 1'b0;
            wr_valid <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (state == INIT) begin
                wr_en              <= 1'b1;
                {wr_bank, wr_addr} <= sweep;
                sweep              <= sweep + 1'b1;
            end else if (state == CLEAR) begin
                if (!sweep[ADDR_W]) begin
                    wr_en   <= 1'b1;
                    wr_bank <= cap_bank;
                    wr_addr <= sweep[ADDR_W-1:0];
                    sweep   <= sweep + 1'b1;
                end
            end else if (swap) begin
                disp_bank     <= cap_bank;
                disp_count    <= wr_ptr;
                disp_overflow <= ovf_pend;
                cap_bank      <= ~cap_bank;
                wr_ptr        <= '0;
                frame_cnt     <= '0;
                dec_cnt       <= '0;
                ovf_pend      <= 1'b0;
                persist_l     <= cfg_persist;
                decim_l       <= cfg_decim;
                sweep         <= {{ADDR_W{1'b0}}, 1'b1};
                wr_en         <= 1'b1;
                wr_bank       <= ~cap_bank;
                wr_addr       <= '0;
            end else begin
                if (frame_start) frame_cnt <= frame_cnt + 4'd1;
                if (eligible) begin
                    dec_cnt <= (dec_cnt == decim_eff - 8'd1) ? 8'd0 : dec_cnt + 8'd1;
                    if (dec_cnt == 8'd0) begin
                        wr_en    <= 1'b1;
                        wr_valid <= 1'b1;
                        wr_bank  <= cap_bank;
                        wr_addr  <= wr_ptr[ADDR_W-1:0];
                        wr_x     <= sym_x;
                        wr_y     <= sym_y;
                        wr_ptr   <= wr_ptr + 1'b1;
                    end
                end
                if (sym_valid && full) ovf_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dot_bank_scheduler.sv
// tb_dot_bank_scheduler: scoreboard bench for the dot bank ping-pong scheduler
module tb_dot_bank_scheduler;
    localparam int DEPTH = 64;
    localparam int X_W = 12;
    localparam int Y_W = 11;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2 + AW + X_W + Y_W;

    typedef struct packed {
        logic        bank;
        logic [AW:0] cnt;
        logic        ovf;
        logic [15:0] drops;
    } snap_t;

    logic clk_pixel = 0, rst = 0, sym_valid = 0, frame_start = 0;
    logic [X_W-1:0] sym_x = '0;
    logic [Y_W-1:0] sym_y = '0;
    logic [3:0] cfg_persist = 4'd1;
    logic [7:0] cfg_decim = 8'd1;
    logic wr_en, wr_valid, wr_bank, disp_bank, disp_overflow, busy;
    logic [AW-1:0] wr_addr;
    logic [X_W-1:0] wr_x;
    logic [Y_W-1:0] wr_y;
    logic [AW:0] disp_count;
    logic [15:0] drop_cnt;

    dot_bank_scheduler #(.DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk_pixel(clk_pixel), .rst(rst), .sym_valid(sym_valid), .sym_x(sym_x), .sym_y(sym_y),
        .frame_start(frame_start), .cfg_persist(cfg_persist), .cfg_decim(cfg_decim),
        .wr_en(wr_en), .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .disp_bank(disp_bank), .disp_count(disp_count),
        .disp_overflow(disp_overflow), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    logic [PW-1:0] exp_wr[$];
    snap_t exp_disp[$];
    snap_t got_snap;
    logic prev_dbank = 1'b1;
    int compared = 0, mismatched = 0;

    int m_block, m_cap, m_ptr, m_frames, m_dec, m_ovf, m_persist, m_decim;
    logic [15:0] m_drops;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [PW-1:0] pack(bit v, bit b, int a, logic [X_W-1:0] x, logic [Y_W-1:0] y);
        return {v, b, AW'(a), x, y};
    endfunction

    function automatic void count_drop();
        if (m_drops != 16'hFFFF) m_drops++;
    endfunction

    // Reference model: one call per sampled clock edge with the inputs seen at that edge
    task automatic model_step(bit sv, logic [X_W-1:0] x, logic [Y_W-1:0] y, bit fs);
        int np, nd;
        snap_t s;
        if (m_block > 0) begin
            m_block--;
            if (sv) count_drop();
            return;
        end
        np = (m_persist == 0) ? 1 : m_persist;
        nd = (m_decim <= 1) ? 1 : m_decim;
        if (fs && m_frames + 1 >= np) begin
            if (sv) count_drop();
            s.bank = m_cap[0];
            s.cnt = (AW + 1)'(m_ptr);
            s.ovf = m_ovf[0];
            s.drops = m_drops;
            exp_disp.push_back(s);
            m_cap ^= 1;
            m_ptr = 0;
            m_frames = 0;
            m_dec = 0;
            m_ovf = 0;
            m_persist = cfg_persist;
            m_decim = cfg_decim;
            for (int k = 0; k < DEPTH; k++) exp_wr.push_back(pack(0, m_cap[0], k, '0, '0));
            m_block = DEPTH;
            return;
        end
        if (fs) m_frames++;
        if (sv) begin
            if (m_ptr == DEPTH) begin
                count_drop();
                m_ovf = 1;
            end else begin
                if (m_dec == 0) begin
                    exp_wr.push_back(pack(1, m_cap[0], m_ptr, x, y));
                    m_ptr++;
                end
                m_dec = (m_dec + 1) % nd;
            end
        end
    endtask

    task automatic step(bit sv, bit fs, logic [X_W-1:0] x, logic [Y_W-1:0] y);
        sym_valid = sv;
        frame_start = fs;
        sym_x = x;
        sym_y = y;
        @(posedge clk_pixel);
        model_step(sv, x, y, fs);
        #1;
        sym_valid = 0;
        frame_start = 0;
    endtask

    task automatic rsym();
        step(1, 0, X_W'($urandom), Y_W'($urandom));
    endtask

    task automatic settle();
        while (m_block > 0) step(0, 0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1;
        exp_wr.delete();
        exp_disp.delete();
        m_block = 0; m_cap = 0; m_ptr = 0; m_frames = 0; m_dec = 0; m_ovf = 0;
        m_persist = 1; m_decim = 1; m_drops = 0;
        #1;
        check("rst_wr_en", 64'(wr_en), 0);
        check("rst_wr_valid", 64'(wr_valid), 0);
        check("rst_wr_bank", 64'(wr_bank), 0);
        check("rst_wr_addr", 64'(wr_addr), 0);
        check("rst_disp_bank", 64'(disp_bank), 1);
        check("rst_disp_count", 64'(disp_count), 0);
        check("rst_disp_overflow", 64'(disp_overflow), 0);
        check("rst_drop_cnt", 64'(drop_cnt), 0);
        check("rst_busy", 64'(busy), 1);
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1;
        rst = 0;
        for (int i = 0; i < 2 * DEPTH; i++) exp_wr.push_back(pack(0, i >= DEPTH, i % DEPTH, '0, '0));
        m_block = 2 * DEPTH;
    endtask

    // Monitor: every RAM write and every display-bank swap is checked against the scoreboard
    always @(negedge clk_pixel) begin
        if (!rst) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) check("write_expected", 64'(exp_wr.size()), 1);
                else check("write", 64'({wr_valid, wr_bank, wr_addr, wr_x, wr_y}), 64'(exp_wr.pop_front()));
            end
            if (disp_bank != prev_dbank) begin
                if (exp_disp.size() == 0) check("swap_expected", 64'(exp_disp.size()), 1);
                else begin
                    got_snap = exp_disp.pop_front();
                    check("disp_bank", 64'(disp_bank), 64'(got_snap.bank));
                    check("disp_count", 64'(disp_count), 64'(got_snap.cnt));
                    check("disp_overflow", 64'(disp_overflow), 64'(got_snap.ovf));
                    check("drop_cnt_at_swap", 64'(drop_cnt), 64'(got_snap.drops));
                    check("busy_after_swap", 64'(busy), 1);
                end
            end
        end
        prev_dbank <= disp_bank;
    end

    initial begin
        #1;
        do_reset();
        settle();
        step(0, 0, '0, '0);
        check("busy_after_init", 64'(busy), 0);
        check("disp_bank_after_init", 64'(disp_bank), 1);
        step(1, 0, 12'd100, 11'd50);
        step(1, 0, 12'd200, 11'd60);
        step(1, 0, 12'd300, 11'd70);
        step(0, 1, '0, '0);
        settle();
        for (int i = 0; i < 70; i++) rsym();
        step(0, 1, '0, '0);
        settle();
        step(0, 1, '0, '0);
        settle();
        cfg_decim = 8'd3;
        step(0, 1, '0, '0);
        settle();
        cfg_decim = 8'd1;
        for (int i = 0; i < 9; i++) rsym();
        cfg_persist = 4'd2;
        step(0, 1, '0, '0);
        settle();
        cfg_persist = 4'd1;
        rsym();
        step(0, 1, '0, '0);
        rsym();
        rsym();
        step(0, 1, '0, '0);
        settle();
        rsym();
        step(1, 1, 12'd7, 11'd9);
        rsym();
        rsym();
        settle();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) cfg_persist = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) cfg_decim = 8'($urandom_range(0, 4));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 119) == 0, X_W'($urandom), Y_W'($urandom));
        end
        settle();
        cfg_persist = 4'd1;
        cfg_decim = 8'd1;
        for (int i = 0; i < 5; i++) rsym();
        step(0, 1, '0, '0);
        repeat (10) step(0, 0, '0, '0);
        do_reset();
        settle();
        for (int i = 0; i < 4; i++) rsym();
        step(0, 1, '0, '0);
        settle();
        repeat (5) step(0, 0, '0, '0);
        @(negedge clk_pixel);
        #1;
        check("writes_drained", 64'(exp_wr.size()), 0);
        check("swaps_drained", 64'(exp_disp.size()), 0);
        check("final_drop_cnt", 64'(drop_cnt), 64'(m_drops));
        check("final_busy", 64'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dot_bank_scheduler.md
# dot_bank_scheduler

Ping-pong controller for the constellation dot memory on the pixel clock. It accepts screen-space symbol coordinates and writes them into a capture bank. On a programmable frame boundary it swaps capture and display banks and sweeps the new capture bank clear, so the renderer always reads a stable, complete bank. It sits between the symbol CDC/coordinate stage and the dual-bank dot RAM read by the renderer.

## Interface
Parameters:
- DEPTH, 64, dots per bank; power of two, ≥4. ADDR_W = $clog2(DEPTH) is derived.
- X_W, 12, pixel X width.
- Y_W, 11, pixel Y width.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- sym_valid  in  1  one-cycle strobe, already synchronised to clk_pixel.
- sym_x  in  X_W  clipped pixel X, valid with sym_valid.
- sym_y  in  Y_W  clipped pixel Y, valid with sym_valid.
- frame_start  in  1  one-cycle pulse at the vsync rising edge.
- cfg_persist  in  4  frames accumulated per bank; 0 is treated as 1.
- cfg_decim  in  8  keep 1 of every N eligible symbols; 0 and 1 both mean keep all.
- wr_en  out  1  dot RAM write strobe.
- wr_valid  out  1  valid bit to write: 1 = dot, 0 = clear.
- wr_bank  out  1  bank being written.
- wr_addr  out  ADDR_W  entry index.
- wr_x  out  X_W  data X; 0 during clears.
- wr_y  out  Y_W  data Y; 0 during clears.
- disp_bank  out  1  bank the renderer reads.
- disp_count  out  ADDR_W+1  valid dots in the display bank.
- disp_overflow  out  1  display bank's capture period dropped symbols for full.
- drop_cnt  out  16  saturating count of all dropped symbols.
- busy  out  1  state ≠ CAPTURE.

## Operation
- States: INIT, CLEAR, CAPTURE.
- INIT (entered on reset): sweeps {bank,addr} from 0 to 2·DEPTH−1, one write per cycle, wr_valid=0. It then moves to CAPTURE with capture bank 0 and disp_bank=1.
- CAPTURE: on sym_valid, the symbol is eligible if wr_ptr<DEPTH.
  - The decimation counter advances only on eligible symbols.
  - The symbol is written when the counter is 0; the counter wraps at N−1.
  - A written symbol goes to {capture bank, wr_ptr} and wr_ptr increments.
  - If wr_ptr==DEPTH, the symbol is dropped: drop_cnt+1 and ovf_pend is set.
- Frame counting (CAPTURE only): frame_start increments frame_cnt. When frame_cnt+1 ≥ latched persist, a swap occurs.
- Swap:
  - disp_bank ← capture bank; disp_count ← wr_ptr; disp_overflow ← ovf_pend.
  - The capture bank flips.
  - wr_ptr, frame_cnt, the decimation counter and ovf_pend reset to 0.
  - cfg_persist and cfg_decim are latched.
  - State → CLEAR.
- CLEAR: sweeps addr 0..DEPTH−1 of the new capture bank with wr_valid=0, then → CAPTURE.
- Outside CAPTURE: sym_valid is dropped and counted in drop_cnt; frame_start is ignored.
- Simultaneous sym_valid and a swapping frame_start: the swap wins and the symbol is dropped and counted. If frame_start does not swap, the symbol is processed normally.
- drop_cnt saturates at 0xFFFF and clears only on reset.
- Latched persist and decimation values reset to 1.

## Timing
- Reset values:
  - All outputs 0, except disp_bank=1 and busy=1.
  - Internal state = INIT at address 0.
- First INIT write (wr_en=1) occurs in the first cycle after rst deasserts. INIT lasts 2·DEPTH cycles.
- Write latency: a sym_valid sampled at edge T gives wr_en high in cycle T+1. wr_* are registered, and wr_en is high for exactly one cycle.
- Swap on frame_start at edge T:
  - From T+1: disp_bank, disp_count and disp_overflow are updated and busy=1.
  - CLEAR writes addr k at cycle T+1+k.
  - CAPTURE resumes at T+DEPTH+1; a sym_valid sampled there is accepted.
- Display outputs change only at a swap, and never mid-frame relative to frame_start.
- Reset asserted mid-operation immediately forces reset values. Any RAM write in progress is abandoned; INIT then rewrites both banks.

## Test plan
- Reset release, DEPTH=64: wr_en high for 128 consecutive cycles with wr_valid=0, {bank,addr} from 0 to 127; then busy=0 and disp_bank=1.
- Three symbols (100,50), (200,60), (300,70), then frame_start with persist=1:
  - Writes to bank 0 at addr 0..2.
  - disp_bank=0, disp_count=3.
  - Then 64 clears to bank 1.
- 70 symbols within one period, then swap: 64 writes, drop_cnt=6, disp_count=64, disp_overflow=1. The next swap with no overflow gives disp_overflow=0.
- cfg_decim=3 latched, 9 symbols: writes only for symbols 1, 4 and 7, at addr 0, 1 and 2.
- cfg_persist=2 latched: the first frame_start does not swap; the second frame_start does swap.
- frame_start and sym_valid in the same cycle at a swap: symbol dropped and drop_cnt+1. sym_valid during CLEAR is dropped and counted.
